// File: rtl/tytra_ctrl_pkg.sv
// Shared definitions for the kernel control register file: register map,
// CTRL bit positions, channel FSM states and a byte-strobe merge helper.
package tytra_ctrl_pkg;

  localparam int unsigned ADDR_CTRL    = 'h00;
  localparam int unsigned ADDR_GIE     = 'h04;
  localparam int unsigned ADDR_IER     = 'h08;
  localparam int unsigned ADDR_ISR     = 'h0C;
  localparam int unsigned ADDR_PTR0_LO = 'h10;
  localparam int unsigned ADDR_PTR0_HI = 'h14;
  localparam int unsigned ADDR_PTR1_LO = 'h1C;
  localparam int unsigned ADDR_PTR1_HI = 'h20;

  localparam int unsigned CTRL_AP_START     = 0;
  localparam int unsigned CTRL_AP_DONE      = 1;
  localparam int unsigned CTRL_AP_IDLE      = 2;
  localparam int unsigned CTRL_AP_READY     = 3;
  localparam int unsigned CTRL_AUTO_RESTART = 7;

  // The *RESET states keep the ready outputs low for the first cycle after reset.
  typedef enum logic [1:0] {
    WRIDLE  = 2'd0,
    WRDATA  = 2'd1,
    WRRESP  = 2'd2,
    WRRESET = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RDIDLE  = 2'd0,
    RDDATA  = 2'd1,
    RDRESET = 2'd3
  } rd_state_t;

  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tytra_kernel_control_s_axi_if.sv
// AXI4-Lite control channel bundle between the host interconnect and the
// kernel control register file.
interface tytra_kernel_control_s_axi_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/tytra_kernel_control_s_axi.sv
// AXI4-Lite control register file for the kernel: start/done/idle handshake,
// interrupt enable/status and two 64-bit buffer pointers.
module tytra_kernel_control_s_axi
  import tytra_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  tytra_kernel_control_s_axi_if.slave s_axi_control,
  output logic                        interrupt,
  output logic                        ap_start,
  input  logic                        ap_done,
  input  logic                        ap_idle,
  output logic [63:0]                 axi00_ptr0,
  output logic [63:0]                 axi00_ptr1
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] A_CTRL    = AW'(ADDR_CTRL);
  localparam logic [AW-1:0] A_GIE     = AW'(ADDR_GIE);
  localparam logic [AW-1:0] A_IER     = AW'(ADDR_IER);
  localparam logic [AW-1:0] A_ISR     = AW'(ADDR_ISR);
  localparam logic [AW-1:0] A_PTR0_LO = AW'(ADDR_PTR0_LO);
  localparam logic [AW-1:0] A_PTR0_HI = AW'(ADDR_PTR0_HI);
  localparam logic [AW-1:0] A_PTR1_LO = AW'(ADDR_PTR1_LO);
  localparam logic [AW-1:0] A_PTR1_HI = AW'(ADDR_PTR1_HI);

  wr_state_t                     wr_state;
  rd_state_t                     rd_state;
  logic [AW-1:0]                 waddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [31:0]                   rd_mux;
  logic [31:0]                   wdata;
  logic [3:0]                    wstrb;
  logic                          aw_hs, w_hs, ar_hs;
  logic                          wr_ctrl, wr_gie, wr_ier, wr_isr;
  logic                          wr_p0_lo, wr_p0_hi, wr_p1_lo, wr_p1_hi;

  logic        int_ap_start;
  logic        int_restart_pend;
  logic        int_auto_restart;
  logic        int_ap_done;
  logic        int_ap_idle;
  logic        int_gie;
  logic        int_ier;
  logic        int_isr;
  logic        int_irq;
  logic [63:0] int_ptr0;
  logic [63:0] int_ptr1;

  assign s_axi_control.awready = (wr_state == WRIDLE);
  assign s_axi_control.wready  = (wr_state == WRDATA);
  assign s_axi_control.bvalid  = (wr_state == WRRESP);
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = (rd_state == RDIDLE);
  assign s_axi_control.rvalid  = (rd_state == RDDATA);
  assign s_axi_control.rresp   = 2'b00;
  assign s_axi_control.rdata   = rdata_q;

  assign aw_hs = s_axi_control.awvalid & s_axi_control.awready;
  assign w_hs  = s_axi_control.wvalid  & s_axi_control.wready;
  assign ar_hs = s_axi_control.arvalid & s_axi_control.arready;
  assign wdata = s_axi_control.wdata;
  assign wstrb = s_axi_control.wstrb;

  assign wr_ctrl  = w_hs && (waddr_q == A_CTRL);
  assign wr_gie   = w_hs && (waddr_q == A_GIE);
  assign wr_ier   = w_hs && (waddr_q == A_IER);
  assign wr_isr   = w_hs && (waddr_q == A_ISR);
  assign wr_p0_lo = w_hs && (waddr_q == A_PTR0_LO);
  assign wr_p0_hi = w_hs && (waddr_q == A_PTR0_HI);
  assign wr_p1_lo = w_hs && (waddr_q == A_PTR1_LO);
  assign wr_p1_hi = w_hs && (waddr_q == A_PTR1_HI);

  assign interrupt  = int_irq;
  assign ap_start   = int_ap_start;
  assign axi00_ptr0 = int_ptr0;
  assign axi00_ptr1 = int_ptr1;

  // Write channel
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state <= WRRESET;
      waddr_q  <= '0;
    end else begin
      if (aw_hs) waddr_q <= s_axi_control.awaddr;
      case (wr_state)
        WRRESET: wr_state <= WRIDLE;
        WRIDLE:  if (aw_hs) wr_state <= WRDATA;
        WRDATA:  if (w_hs) wr_state <= WRRESP;
        WRRESP:  if (s_axi_control.bready) wr_state <= WRIDLE;
        default: wr_state <= WRIDLE;
      endcase
    end
  end

  // Read channel
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state <= RDRESET;
      rdata_q  <= '0;
    end else begin
      if (ar_hs) rdata_q <= rd_mux;
      case (rd_state)
        RDRESET: rd_state <= RDIDLE;
        RDIDLE:  if (ar_hs) rd_state <= RDDATA;
        RDDATA:  if (s_axi_control.rready) rd_state <= RDIDLE;
        default: rd_state <= RDIDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_control.araddr)
      A_CTRL: begin
        rd_mux[CTRL_AP_START]     = int_ap_start;
        rd_mux[CTRL_AP_DONE]      = int_ap_done;
        rd_mux[CTRL_AP_IDLE]      = int_ap_idle;
        rd_mux[CTRL_AP_READY]     = int_ap_done;
        rd_mux[CTRL_AUTO_RESTART] = int_auto_restart;
      end
      A_GIE:     rd_mux[0] = int_gie;
      A_IER:     rd_mux[0] = int_ier;
      A_ISR:     rd_mux[0] = int_isr;
      A_PTR0_LO: rd_mux    = int_ptr0[31:0];
      A_PTR0_HI: rd_mux    = int_ptr0[63:32];
      A_PTR1_LO: rd_mux    = int_ptr1[31:0];
      A_PTR1_HI: rd_mux    = int_ptr1[63:32];
      default:   rd_mux    = '0;
    endcase
  end

  // Auto-restart re-raises ap_start one cycle after the done-driven clear,
  // giving the kernel a falling edge to re-arm its edge detector.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      int_ap_start     <= 1'b0;
      int_restart_pend <= 1'b0;
      int_auto_restart <= 1'b0;
    end else begin
      int_restart_pend <= ap_done && int_auto_restart;
      if (wr_ctrl && wstrb[0] && wdata[CTRL_AP_START])
        int_ap_start <= 1'b1;
      else if (int_restart_pend)
        int_ap_start <= 1'b1;
      else if (ap_done)
        int_ap_start <= 1'b0;
      if (wr_ctrl && wstrb[0])
        int_auto_restart <= wdata[CTRL_AUTO_RESTART];
    end
  end

  // Status set by the kernel takes priority over clear-on-read and toggle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      int_ap_done <= 1'b0;
      int_ap_idle <= 1'b0;
      int_gie     <= 1'b0;
      int_ier     <= 1'b0;
      int_isr     <= 1'b0;
      int_irq     <= 1'b0;
    end else begin
      int_ap_idle <= ap_idle;
      int_irq     <= int_gie & int_isr;
      if (ap_done)
        int_ap_done <= 1'b1;
      else if (ar_hs && (s_axi_control.araddr == A_CTRL))
        int_ap_done <= 1'b0;
      if (wr_gie && wstrb[0]) int_gie <= wdata[0];
      if (wr_ier && wstrb[0]) int_ier <= wdata[0];
      if (ap_done && int_ier)
        int_isr <= 1'b1;
      else if (wr_isr && wstrb[0] && wdata[0])
        int_isr <= ~int_isr;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      int_ptr0 <= '0;
      int_ptr1 <= '0;
    end else begin
      if (wr_p0_lo) int_ptr0[31:0]  <= wstrb_merge(int_ptr0[31:0],  wdata, wstrb);
      if (wr_p0_hi) int_ptr0[63:32] <= wstrb_merge(int_ptr0[63:32], wdata, wstrb);
      if (wr_p1_lo) int_ptr1[31:0]  <= wstrb_merge(int_ptr1[31:0],  wdata, wstrb);
      if (wr_p1_hi) int_ptr1[63:32] <= wstrb_merge(int_ptr1[63:32], wdata, wstrb);
    end
  end

endmodule
